// File: rtl/led_blink_meter.sv
// led_blink_meter: measures the half-period of a blinking input in clock cycles.
//
// The input is synchronized, turned into accepted edges (either direction), and
// the cycles between consecutive accepted edges are reported. A two-state FSM
// waits for a first edge (SEEK), then measures every interval (MEASURE). When no
// edge arrives for TIMEOUT_CYC cycles the meter drops back to SEEK and raises a
// sticky timeout flag.
//
// Optional feature: define LED_BLINK_METER_GLITCH_FILTER_EN to accept a level
// change only after it has been stable for 3 cycles (adds 2 cycles of latency).
//
// Parameters:
//   CNT_W        width of the interval counter and of half_period_out
//   TIMEOUT_CYC  idle cycles before the input is declared dead (<= 2^CNT_W-1)
//   TOL          max difference between consecutive measurements for lock
// Ports:
//   clk_in1          clock, all state on the rising edge
//   rst_in1          synchronous active-high reset
//   led_in1          asynchronous blinking input
//   half_period_out  last measured half-period in clk_in1 cycles
//   valid_out1       one-cycle pulse when half_period_out updates
//   locked_out1      consecutive measurements agree within TOL
//   timeout_out1     sticky: input static for TIMEOUT_CYC cycles
module led_blink_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TOL         = 1
) (
  input  logic             clk_in1,
  input  logic             rst_in1,
  input  logic             led_in1,
  output logic [CNT_W-1:0] half_period_out,
  output logic             valid_out1,
  output logic             locked_out1,
  output logic             timeout_out1
);

  typedef enum logic {SEEK, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W:0]   TOL_V  = (CNT_W+1)'(TOL);

  // input conditioning
  logic s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, edge_q, edge_d, det;
`ifdef LED_BLINK_METER_GLITCH_FILTER_EN
  logic [1:0] stab_q, stab_d;
`endif

  // measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, hp_d, prev_q, prev_d, diff;
  logic             has_prev_q, has_prev_d, valid_q, valid_d;
  logic             lock_q, lock_d, to_q, to_d, match;

  always_comb begin
    s1_d  = led_in1;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    det   = 1'b0;
`ifdef LED_BLINK_METER_GLITCH_FILTER_EN
    // stab_q counts earlier consecutive cycles the synchronized level has
    // differed from the accepted one; the third differing cycle accepts it.
    stab_d = 2'd0;
    if (s2_q != lvl_q) begin
      if (stab_q == 2'd2) begin
        det   = 1'b1;
        lvl_d = s2_q;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
`else
    det   = (s2_q != lvl_q);
    lvl_d = s2_q;
`endif
    // registering the detection gives the 3-cycle input-to-valid latency
    edge_d = det;
  end

  assign diff  = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
  assign match = has_prev_q && ({1'b0, diff} <= TOL_V);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hp_d       = hp_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    valid_d    = 1'b0;
    lock_d     = lock_q;
    to_d       = to_q;
    case (state_q)
      SEEK: begin
        cnt_d = '0;
        if (edge_q) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
          to_d    = 1'b0;
        end
      end
      MEASURE: begin
        // cnt_q holds the cycles elapsed since the previous accepted edge;
        // an edge on the threshold cycle takes priority over the timeout.
        if (edge_q) begin
          hp_d       = cnt_q;
          valid_d    = 1'b1;
          lock_d     = match;
          prev_d     = cnt_q;
          has_prev_d = 1'b1;
          cnt_d      = CNT_W'(1);
        end else if (cnt_q >= TO_VAL) begin
          state_d    = SEEK;
          to_d       = 1'b1;
          lock_d     = 1'b0;
          has_prev_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (rst_in1) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_q      <= 1'b0;
      edge_q     <= 1'b0;
`ifdef LED_BLINK_METER_GLITCH_FILTER_EN
      stab_q     <= 2'd0;
`endif
      state_q    <= SEEK;
      cnt_q      <= '0;
      hp_q       <= '0;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_q      <= lvl_d;
      edge_q     <= edge_d;
`ifdef LED_BLINK_METER_GLITCH_FILTER_EN
      stab_q     <= stab_d;
`endif
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      to_q       <= to_d;
    end
  end

  assign half_period_out = hp_q;
  assign valid_out1      = valid_q;
  assign locked_out1     = lock_q;
  assign timeout_out1    = to_q;

endmodule

// File: tb/tb_led_blink_meter.sv
// Bench for led_blink_meter: two instances (default parameters, and an 8-bit
// meter with a 200-cycle timeout) share the same inputs. A time-based model
// derives accepted edges from the sampled input history and predicts every
// output on every cycle.
module tb_led_blink_meter;

`ifdef LED_BLINK_METER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int TOL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led = 1'b0;
  logic [15:0] hp0;
  logic [7:0]  hp1;
  logic v0, l0, t0, v1, l1, t1;

  always #5 clk = ~clk;

  led_blink_meter dut0 (
    .clk_in1(clk), .rst_in1(rst), .led_in1(led),
    .half_period_out(hp0), .valid_out1(v0), .locked_out1(l0), .timeout_out1(t0)
  );

  led_blink_meter #(.CNT_W(8), .TIMEOUT_CYC(200), .TOL(TOL)) dut1 (
    .clk_in1(clk), .rst_in1(rst), .led_in1(led),
    .half_period_out(hp1), .valid_out1(v1), .locked_out1(l1), .timeout_out1(t1)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int cyc = 10;
  bit samp [0:65535];
  bit acc = 1'b0;
  int to_lim [2] = '{65535, 200};
  bit m_seek [2] = '{1'b1, 1'b1};
  int m_last [2] = '{0, 0};
  int m_prev [2] = '{0, 0};
  bit m_hasp [2] = '{1'b0, 1'b0};
  int e_hp   [2] = '{0, 0};
  bit e_v    [2] = '{1'b0, 1'b0};
  bit e_l    [2] = '{1'b0, 1'b0};
  bit e_t    [2] = '{1'b0, 1'b0};

  function automatic logic [18:0] obs(int i);
    if (i == 0) return {hp0, v0, l0, t0};
    return {8'd0, hp1, v1, l1, t1};
  endfunction

  function automatic logic [18:0] expv(int i);
    return {16'(e_hp[i]), e_v[i], e_l[i], e_t[i]};
  endfunction

  // advance one clock, update the model, return #1 after the edge
  task automatic tick();
    bit edge_ev;
    int meas, d;
    @(posedge clk);
    cyc++;
    samp[cyc] = led;
    edge_ev = 1'b0;
    if (rst) begin
      // levels captured before or at reset are lost from the synchronizer
      for (int k = 0; k <= 5; k++) samp[cyc-k] = 1'b0;
      acc = 1'b0;
    end else if (!FILT) begin
      if (samp[cyc-3] != acc) begin edge_ev = 1'b1; acc = samp[cyc-3]; end
    end else begin
      if (samp[cyc-3] == samp[cyc-4] && samp[cyc-4] == samp[cyc-5] && samp[cyc-3] != acc) begin
        edge_ev = 1'b1; acc = samp[cyc-3];
      end
    end
    for (int i = 0; i < 2; i++) begin
      e_v[i] = 1'b0;
      if (rst) begin
        m_seek[i] = 1'b1; m_hasp[i] = 1'b0; m_prev[i] = 0;
        e_hp[i] = 0; e_l[i] = 1'b0; e_t[i] = 1'b0;
      end else if (edge_ev) begin
        if (m_seek[i]) begin
          m_seek[i] = 1'b0; e_t[i] = 1'b0;
        end else begin
          meas = cyc - m_last[i];
          d = meas - m_prev[i];
          if (d < 0) d = -d;
          e_v[i] = 1'b1; e_hp[i] = meas;
          e_l[i] = m_hasp[i] && (d <= TOL);
          m_prev[i] = meas; m_hasp[i] = 1'b1;
        end
        m_last[i] = cyc;
      end else if (!m_seek[i] && (cyc - m_last[i]) >= to_lim[i]) begin
        m_seek[i] = 1'b1; m_hasp[i] = 1'b0; e_t[i] = 1'b1; e_l[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; led = 1'b0;
    repeat (3) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== 19'd0) begin
          miscompares++;
          $display("FAIL reset dut%0d got=%h exp=0", i, obs(i));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_blink_1024();
    for (int j = 0; j < 5; j++) begin
      led = ~led;
      repeat (1024) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL blink1024 cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
    vectors++;
    if (hp0 !== 16'd1024 || l0 !== 1'b1) begin
      miscompares++;
      $display("FAIL blink1024_final hp=%0d lock=%b exp hp=1024 lock=1", hp0, l0);
    end
  endtask

  task automatic test_tol_lock();
    int gaps [5] = '{300, 100, 100, 101, 104};
    for (int j = 0; j < 5; j++) begin
      led = ~led;
      repeat (gaps[j]) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL tol_lock cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    // 300 lets dut1 settle into SEEK; 200 and 201 probe the threshold cycle
    int gaps [7] = '{300, 50, 250, 60, 200, 201, 30};
    int last_v1, rise;
    last_v1 = -1; rise = -1;
    for (int j = 0; j < 7; j++) begin
      led = ~led;
      repeat (gaps[j]) begin
        tick();
        if (v1) last_v1 = cyc;
        if (j == 2 && t1 && rise < 0) rise = cyc - last_v1;
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL timeout cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
    vectors++;
    if (rise !== 200) begin
      miscompares++;
      $display("FAIL timeout_delay got=%0d exp=200", rise);
    end
  endtask

  task automatic test_reset_mid();
    int gaps [5] = '{64, 64, 30, 64, 64};
    for (int j = 0; j < 5; j++) begin
      if (j != 3) led = ~led;
      if (j == 3) rst = 1'b1;
      repeat (gaps[j]) begin
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL reset_mid cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    int seg [4] = '{100, 2, 198, 150};
    for (int j = 0; j < 4; j++) begin
      if (j != 2) led = ~led;
      else led = ~led;
      repeat (seg[j]) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL glitch cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int j = 0; j < 60; j++) begin
      gap = (j % 7 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(90, 260));
      led = ~led;
      if ($urandom_range(0, 14) == 0) rst = 1'b1;
      repeat (gap) begin
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs(i) !== expv(i)) begin
            miscompares++;
            $display("FAIL random cyc=%0d dut%0d got=%h exp=%h", cyc, i, obs(i), expv(i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink_1024();
    test_tol_lock();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
